// File: rtl/aes_rx_block_assembler_pkg.sv
// Shared definitions for the AES receive-side block assembler.
// Holds the controller state encoding, the AES block geometry and the
// idle-timer width used by the assembler and its timer.
package aes_rx_defs;

  typedef enum logic [1:0] {
    CTRL_COLLECT   = 2'h0,
    CTRL_START     = 2'h1,
    CTRL_WAIT_BUSY = 2'h2,
    CTRL_WAIT_DONE = 2'h3
  } ctrl_state_t;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int BLOCK_W         = AES_BLOCK_BYTES * 8;
  localparam int TIMER_W         = 20;

endpackage

// File: rtl/aes_rx_block_assembler_if.sv
// Signal bundle between the assembler, the byte receiver, the decipher core
// and the TX path.
//   rx_data/rx_valid      : byte strobe from the receiver (no back-pressure)
//   block/next            : ciphertext and one-cycle start pulse to the core
//   core_ready/core_result: core handshake and plaintext
//   result/result_valid   : captured plaintext and its update pulse
//   busy/overrun/timeout  : status
//   dbg_state/dbg_byte_ctr: controller state and byte count, observation only
// Core handshake: a block is launched only in a cycle where next and
// core_ready are both high; the core then drops core_ready while it works
// and raises it again with core_result valid in that same cycle.
// modport master is the assembler's view, modport slave is the environment's.
interface aes_rx_block_assembler_if;
  import aes_rx_defs::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [BLOCK_W-1:0] block;
  logic               next;
  logic               core_ready;
  logic [BLOCK_W-1:0] core_result;
  logic [BLOCK_W-1:0] result;
  logic               result_valid;
  logic               busy;
  logic               overrun;
  logic               timeout;
  ctrl_state_t        dbg_state;
  logic [3:0]         dbg_byte_ctr;

  modport master (
    input  rx_data, rx_valid, core_ready, core_result,
    output block, next, result, result_valid, busy, overrun, timeout,
    output dbg_state, dbg_byte_ctr
  );

  modport slave (
    output rx_data, rx_valid, core_ready, core_result,
    input  block, next, result, result_valid, busy, overrun, timeout,
    input  dbg_state, dbg_byte_ctr
  );

endinterface

// File: rtl/aes_rx_block_assembler_timer.sv
// Idle timer for partial blocks.
//   clk, reset_n : clock and synchronous active-high reset
//   clear        : return the count to zero
//   enable       : count this cycle as idle
//   expire       : this enabled cycle is the TIMEOUT_CYCLES-th idle cycle
// The count restarts from zero after expiry so a fresh partial block gets a
// full window.
module rx_idle_timer
  import aes_rx_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;

  // count_q holds the number of idle cycles already seen, so the current
  // cycle completes the window when count_q == TIMEOUT_CYCLES-1.
  assign expire = enable && !clear && (count_q == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      count_q <= '0;
    end else if (clear || expire) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/aes_rx_block_assembler.sv
// AES receive-side block assembler.
// Shifts 16 received bytes into a 128-bit ciphertext block (first byte ends
// up in [127:120]), launches the decipher core with a one-cycle next pulse,
// waits for the core to finish and captures its plaintext for the TX path.
// A partial block that sees no bytes for TIMEOUT_CYCLES cycles is abandoned
// so one lost byte cannot misalign every later block.
//   clk     : system clock
//   reset_n : synchronous, active-high reset
//   bus     : aes_rx_block_assembler_if.master (see interface header)
module aes_rx_block_assembler
  import aes_rx_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                      clk,
  input logic                      reset_n,
  aes_rx_block_assembler_if.master bus
);

  ctrl_state_t        state_q, state_d;
  logic [3:0]         byte_ctr_q;
  logic [BLOCK_W-1:0] block_q;
  logic [BLOCK_W-1:0] result_q;
  logic               result_valid_q;
  logic               busy_q;
  logic               overrun_q;
  logic               timeout_q;

  logic in_collect;
  logic accept;
  logic last_byte;
  logic capture;
  logic timer_en;
  logic expire;

  assign in_collect = (state_q == CTRL_COLLECT);
  assign accept     = in_collect && bus.rx_valid;
  assign last_byte  = (byte_ctr_q == 4'(AES_BLOCK_BYTES - 1));

  // Only a partial block is timed; an arriving byte always beats expiry
  // because it removes the enable for that cycle.
  assign timer_en = in_collect && (byte_ctr_q != 4'd0) && !bus.rx_valid;

  rx_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (!timer_en),
    .enable (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= CTRL_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      CTRL_COLLECT:   if (accept && last_byte) state_d = CTRL_START;
      CTRL_START:     if (bus.core_ready) state_d = CTRL_WAIT_BUSY;
      CTRL_WAIT_BUSY: if (!bus.core_ready) state_d = CTRL_WAIT_DONE;
      CTRL_WAIT_DONE: begin
        if (bus.core_ready) begin
          capture = 1'b1;
          state_d = CTRL_COLLECT;
        end
      end
      default:        state_d = CTRL_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      byte_ctr_q     <= '0;
      block_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      result_valid_q <= capture;
      busy_q         <= (state_d != CTRL_COLLECT);
      overrun_q      <= bus.rx_valid && !in_collect;
      timeout_q      <= expire;
      // The 4-bit counter wraps from 15 to 0 on the last byte of a block.
      if (accept) begin
        block_q    <= {block_q[BLOCK_W-9:0], bus.rx_data};
        byte_ctr_q <= byte_ctr_q + 1'b1;
      end else if (expire) begin
        // Stale bytes stay in block_q; the next 16 bytes push them out.
        byte_ctr_q <= '0;
      end
      if (capture) begin
        result_q <= bus.core_result;
      end
    end
  end

  assign bus.next         = (state_q == CTRL_START) && bus.core_ready;
  assign bus.block        = block_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout      = timeout_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_byte_ctr = byte_ctr_q;

endmodule

// File: tb/tb_aes_rx_block_assembler.sv
module tb_aes_rx_block_assembler;
  import aes_rx_defs::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  aes_rx_block_assembler_if bus();

  aes_rx_block_assembler #(.TIMEOUT_CYCLES(10)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]   hist[$];      // accepted bytes, most recent last (last 16 kept)
  int           pending = 0;  // bytes of the block currently being assembled
  logic [127:0] exp_q[$];     // expected ciphertext of each completed block

  function automatic logic [127:0] model_block();
    logic [127:0] r = '0;
    int n = hist.size();
    for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = hist[i];
    return r;
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    hist.push_back(b);
    if (hist.size() > 16) void'(hist.pop_front());
    pending++;
    if (pending == 16) begin
      pending = 0;
      exp_q.push_back(model_block());
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    pending = 0;
    exp_q.delete();
  endfunction

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  // ---------------- decipher core model ----------------
  int           core_lat  = 1;   // cycles ready stays low after a next pulse
  bit           core_hold = 1'b0; // keep ready low while idle
  logic [127:0] core_pt   = '0;

  initial begin
    bit nx;
    bit rs;
    int low_left = 0;
    bus.core_ready  = 1'b1;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      nx = bus.next;
      rs = reset_n;
      @(posedge clk);
      #1;
      if (rs) low_left = 0;
      else if (nx) low_left = core_lat;
      if (low_left > 0) begin
        bus.core_ready  = 1'b0;
        bus.core_result = ~core_pt;
        low_left--;
      end else begin
        bus.core_ready  = !core_hold;
        bus.core_result = core_pt;
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int next_cnt = 0;
  int ov_cnt   = 0;
  int to_cnt   = 0;
  always @(negedge clk) begin
    if (bus.next === 1'b1) next_cnt <= next_cnt + 1;
    if (bus.overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (bus.timeout === 1'b1) to_cnt <= to_cnt + 1;
  end

  // ---------------- drivers ----------------
  task automatic drive_cycle(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.rx_valid = v;
    bus.rx_data  = v ? d : 8'($urandom_range(0, 255));
  endtask

  task automatic send_bytes(input int n, input int gap_min, input int gap_max,
                            input bit seq, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = seq ? base + 8'(i) : 8'($urandom_range(0, 255));
      drive_cycle(1'b1, b);
      model_accept(b);
      if (i != n - 1) repeat ($urandom_range(gap_min, gap_max)) drive_cycle(1'b0, 8'h00);
    end
  endtask

  task automatic wait_rv(input int budget, input string name);
    int n = 0;
    while (bus.result_valid !== 1'b1 && n < budget) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait got no result_valid within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) drive_cycle(1'b0, 8'h00);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (bus.block !== '0) begin errors++; $display("FAIL rst_block got %h want 0", bus.block); end
    checks++; if (bus.next !== 1'b0) begin errors++; $display("FAIL rst_next got %b want 0", bus.next); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL rst_result got %h want 0", bus.result); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b want 0", bus.result_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", bus.overrun); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", bus.timeout); end
    checks++; if (bus.dbg_byte_ctr !== 4'd0) begin errors++; $display("FAIL rst_ctr got %0d want 0", bus.dbg_byte_ctr); end
    checks++; if (bus.dbg_state !== CTRL_COLLECT) begin errors++; $display("FAIL rst_state got %0d want 0", bus.dbg_state); end
  endtask

  task automatic test_basic();
    int n0;
    logic [127:0] exp;
    core_lat = 1; core_hold = 1'b0;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    n0 = next_cnt;
    send_bytes(16, 2, 2, 1'b1, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL basic_next got %b want 1", bus.next); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    checks++; if (bus.block !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL basic_block got %h want 000102030405060708090a0b0c0d0e0f", bus.block); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL basic_model got %h want %h", bus.block, exp); end
    wait_rv(50, "basic");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL basic_result got %h want %h", bus.result, core_pt); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_pulse got %b want 0", bus.result_valid); end
    checks++; if (next_cnt - n0 !== 1) begin errors++; $display("FAIL basic_next_count got %0d want 1", next_cnt - n0); end
  endtask

  task automatic test_slow_core();
    logic [127:0] exp;
    core_lat = 50;
    core_pt = {4{32'hDEADBEEF}};
    send_bytes(16, 0, 3, 1'b0, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL slow_next got %b want 1", bus.next); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL slow_block got %h want %h", bus.block, exp); end
    repeat (20) begin drive_cycle(1'b0, 8'h00); @(negedge clk); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL slow_busy got %b want 1", bus.busy); end
    checks++; if (bus.dbg_state !== CTRL_WAIT_DONE) begin errors++; $display("FAIL slow_state got %0d want 3", bus.dbg_state); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL slow_block_hold got %h want %h", bus.block, exp); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL slow_early_rv got %b want 0", bus.result_valid); end
    wait_rv(100, "slow");
    checks++; if (bus.result !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL slow_result got %h want deadbeef x4", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL slow_busy_fall got %b want 0", bus.busy); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL slow_rv_pulse got %b want 0", bus.result_valid); end
    checks++; if (bus.result !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL slow_result_hold got %h want deadbeef x4", bus.result); end
  endtask

  task automatic test_not_ready();
    int n0;
    logic [127:0] exp;
    core_lat = 2; core_hold = 1'b1;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    n0 = next_cnt;
    send_bytes(16, 0, 0, 1'b0, 8'h00);
    repeat (5) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      checks++; if (bus.next !== 1'b0) begin errors++; $display("FAIL nrdy_next_low got %b want 0", bus.next); end
    end
    checks++; if (bus.dbg_state !== CTRL_START) begin errors++; $display("FAIL nrdy_state got %0d want 1", bus.dbg_state); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nrdy_busy got %b want 1", bus.busy); end
    core_hold = 1'b0;
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL nrdy_next got %b want 1", bus.next); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.next !== 1'b0) begin errors++; $display("FAIL nrdy_next_once got %b want 0", bus.next); end
    wait_rv(50, "nrdy");
    exp = pop_exp();
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL nrdy_block got %h want %h", bus.block, exp); end
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL nrdy_result got %h want %h", bus.result, core_pt); end
    checks++; if (next_cnt - n0 !== 1) begin errors++; $display("FAIL nrdy_next_count got %0d want 1", next_cnt - n0); end
  endtask

  task automatic test_overrun();
    int n = 0;
    int ov0;
    logic [127:0] exp;
    core_lat = 20;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    ov0 = ov_cnt;
    send_bytes(16, 0, 1, 1'b0, 8'h00);
    exp = pop_exp();
    do begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      n++;
    end while (bus.dbg_state !== CTRL_WAIT_DONE && n < 10);
    checks++; if (bus.dbg_state !== CTRL_WAIT_DONE) begin errors++; $display("FAIL ovr_reach_wait got %0d want 3", bus.dbg_state); end
    drive_cycle(1'b1, 8'hA5);
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", bus.overrun); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", bus.overrun); end
    checks++; if (bus.dbg_byte_ctr !== 4'd0) begin errors++; $display("FAIL ovr_ctr got %0d want 0", bus.dbg_byte_ctr); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL ovr_block got %h want %h", bus.block, exp); end
    checks++; if (bus.dbg_state !== CTRL_WAIT_DONE) begin errors++; $display("FAIL ovr_state got %0d want 3", bus.dbg_state); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_len got %b want 0", bus.overrun); end
    wait_rv(50, "ovr");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL ovr_result got %h want %h", bus.result, core_pt); end
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", ov_cnt - ov0); end
    core_lat = 1;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(16, 0, 2, 1'b0, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL ovr_next2 got %b want 1", bus.next); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL ovr_block2 got %h want %h", bus.block, exp); end
    wait_rv(50, "ovr2");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL ovr_result2 got %h want %h", bus.result, core_pt); end
  endtask

  task automatic test_timeout();
    int to0;
    logic [127:0] exp;
    core_lat = 1;
    to0 = to_cnt;
    send_bytes(5, 0, 0, 1'b0, 8'h00);
    repeat (10) drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", bus.timeout); end
    checks++; if (bus.dbg_byte_ctr !== 4'd5) begin errors++; $display("FAIL to_ctr_before got %0d want 5", bus.dbg_byte_ctr); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    pending = 0;
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
    checks++; if (bus.dbg_byte_ctr !== 4'd0) begin errors++; $display("FAIL to_ctr got %0d want 0", bus.dbg_byte_ctr); end
    checks++; if (bus.block !== model_block()) begin errors++; $display("FAIL to_block_kept got %h want %h", bus.block, model_block()); end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len got %b want 0", bus.timeout); end
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(16, 0, 2, 1'b0, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL to_next got %b want 1", bus.next); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL to_block got %h want %h", bus.block, exp); end
    wait_rv(50, "to");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL to_result got %h want %h", bus.result, core_pt); end
    checks++; if (to_cnt - to0 !== 1) begin errors++; $display("FAIL to_count got %0d want 1", to_cnt - to0); end
  endtask

  task automatic test_timeout_race();
    int to0;
    logic [127:0] exp;
    to0 = to_cnt;
    send_bytes(5, 0, 0, 1'b0, 8'h00);
    repeat (9) drive_cycle(1'b0, 8'h00);
    send_bytes(1, 0, 0, 1'b0, 8'h00);
    repeat (3) begin drive_cycle(1'b0, 8'h00); @(negedge clk); end
    checks++; if (to_cnt - to0 !== 0) begin errors++; $display("FAIL race_timeout got %0d pulses want 0", to_cnt - to0); end
    checks++; if (bus.dbg_byte_ctr !== 4'd6) begin errors++; $display("FAIL race_ctr got %0d want 6", bus.dbg_byte_ctr); end
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(10, 0, 1, 1'b0, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL race_next got %b want 1", bus.next); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL race_block got %h want %h", bus.block, exp); end
    wait_rv(50, "race");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL race_result got %h want %h", bus.result, core_pt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [127:0] exp;
    core_lat = 30;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(16, 0, 0, 1'b0, 8'h00);
    do begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      n++;
    end while (bus.dbg_state !== CTRL_WAIT_DONE && n < 10);
    checks++; if (bus.dbg_state !== CTRL_WAIT_DONE) begin errors++; $display("FAIL rmid_reach_wait got %0d want 3", bus.dbg_state); end
    @(posedge clk); #1; reset_n = 1'b1; bus.rx_valid = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (bus.block !== '0) begin errors++; $display("FAIL rmid_block got %h want 0", bus.block); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL rmid_result got %h want 0", bus.result); end
    checks++; if (bus.next !== 1'b0) begin errors++; $display("FAIL rmid_next got %b want 0", bus.next); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rmid_rv got %b want 0", bus.result_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL rmid_status got %b%b want 00", bus.overrun, bus.timeout); end
    checks++; if (bus.dbg_state !== CTRL_COLLECT) begin errors++; $display("FAIL rmid_state got %0d want 0", bus.dbg_state); end
    checks++; if (bus.dbg_byte_ctr !== 4'd0) begin errors++; $display("FAIL rmid_ctr got %0d want 0", bus.dbg_byte_ctr); end
    core_lat = 1;
    core_pt = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(16, 0, 2, 1'b0, 8'h00);
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    exp = pop_exp();
    checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL rmid_next2 got %b want 1", bus.next); end
    checks++; if (bus.block !== exp) begin errors++; $display("FAIL rmid_block2 got %h want %h", bus.block, exp); end
    wait_rv(50, "rmid");
    checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL rmid_result2 got %h want %h", bus.result, core_pt); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    int lat;
    for (int k = 0; k < 3; k++) begin
      lat = $urandom_range(1, 4);
      core_lat = lat;
      core_pt = {$urandom, $urandom, $urandom, $urandom};
      send_bytes((k == 0) ? 16 : 15, 0, 0, 1'b0, 8'h00);
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = pop_exp();
      checks++; if (bus.next !== 1'b1) begin errors++; $display("FAIL b2b_next[%0d] got %b want 1", k, bus.next); end
      checks++; if (bus.block !== exp) begin errors++; $display("FAIL b2b_block[%0d] got %h want %h", k, bus.block, exp); end
      repeat (lat + 1) drive_cycle(1'b0, 8'h00);
      // First byte of the following block lands in the result_valid cycle.
      send_bytes(1, 0, 0, 1'b0, 8'h00);
      @(negedge clk);
      checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv[%0d] got %b want 1", k, bus.result_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d] got %b want 0", k, bus.busy); end
      checks++; if (bus.result !== core_pt) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", k, bus.result, core_pt); end
    end
    drive_cycle(1'b0, 8'h00);
    @(negedge clk);
    checks++; if (bus.dbg_byte_ctr !== 4'd1) begin errors++; $display("FAIL b2b_ctr got %0d want 1", bus.dbg_byte_ctr); end
    checks++; if (bus.block[7:0] !== hist[hist.size()-1]) begin errors++; $display("FAIL b2b_last_byte got %h want %h", bus.block[7:0], hist[hist.size()-1]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_slow_core();
    test_not_ready();
    test_overrun();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_rx_block_assembler.md
# aes_rx_block_assembler

Upstream stage of the AES decipher datapath. Collects 16 ciphertext bytes from the RS232 receiver into a 128-bit block and pulses `next` into the decipher core. Waits for the core's ready handshake, then captures the plaintext for the TX path. Partial blocks are discarded after an idle timeout, so a lost byte cannot permanently misalign the stream.

## Interface
- TIMEOUT_CYCLES, default 1000000: idle cycles after which a partial block is discarded; must be ≥1 and fit in 20 bits.

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-high reset (asserted = 1)
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- block  out  128  assembled ciphertext; first received byte in [127:120]
- next  out  1  one-cycle start pulse to decipher core
- core_ready  in  1  ready from decipher core
- core_result  in  128  new_block from decipher core
- result  out  128  captured plaintext, held until next capture
- result_valid  out  1  one-cycle pulse, result updated
- busy  out  1  high in any state other than COLLECT
- overrun  out  1  one-cycle pulse, byte dropped while busy
- timeout  out  1  one-cycle pulse, partial block discarded

## Operation
- FSM states: COLLECT, START, WAIT_BUSY, WAIT_DONE. Reset state is COLLECT.
- COLLECT, on rx_valid:
  - shift in the byte: block ← {block[119:0], rx_data}; byte_ctr (4 bits) increments.
  - if byte_ctr == 15, byte_ctr wraps to 0 and the FSM moves to START.
- START:
  - if core_ready = 1: next = 1 for this cycle only, then → WAIT_BUSY.
  - else: next stays 0 and the FSM holds in START.
- WAIT_BUSY: → WAIT_DONE when core_ready = 0.
- WAIT_DONE, when core_ready = 1:
  - result ← core_result; result_valid pulses the next cycle.
  - → COLLECT.
- `block` does not change outside COLLECT; it is held stable for the whole core operation.
- rx_valid outside COLLECT: the byte is dropped, overrun pulses the next cycle, and no state or counter changes.
- Idle timer, active only in COLLECT with byte_ctr ≠ 0:
  - counts cycles without rx_valid.
  - on reaching TIMEOUT_CYCLES: byte_ctr ← 0, timeout pulses, block is left unchanged (stale bytes are shifted out by later bytes).
  - any rx_valid clears the timer. Leaving COLLECT clears the timer.
- Simultaneous rx_valid and timer expiry: the byte wins. It is accepted, the timer clears, and no timeout pulse is issued.
- Reset mid-operation returns to COLLECT with all counters cleared. The decipher core shares this reset.

## Timing
- Reset values: block = 0, next = 0, result = 0, result_valid = 0, busy = 0, overrun = 0, timeout = 0, byte_ctr = 0, timer = 0.
- All outputs are registered except `next`, which is decoded from (state == START && core_ready).
- Byte accepted on the rising edge where rx_valid = 1. Back-to-back strobes every cycle are accepted.
- 16th strobe at edge N:
  - state = START and busy = 1 from cycle N+1.
  - next high during cycle N+1 if core_ready = 1.
- Core drops ready one cycle after next. WAIT_BUSY therefore lasts one cycle in normal operation.
- Capture occurs at the edge where core_ready = 1 is seen in WAIT_DONE. result_valid is high the following cycle, and busy falls the same cycle.
- A new byte is accepted in the same cycle result_valid is high.

## Structure
- Shared package / include `aes_rx_defs`:
  - state encodings: CTRL_COLLECT = 2'h0, CTRL_START = 2'h1, CTRL_WAIT_BUSY = 2'h2, CTRL_WAIT_DONE = 2'h3.
  - AES_BLOCK_BYTES = 16.
- Sub-module `rx_idle_timer`: 20-bit counter with inputs clear and enable and output expire; synchronous active-high reset.
- Everything else (FSM, shift register, result capture) lives in the top module.

## Test plan
- Bytes 0x00..0x0F, one strobe every 3 cycles, core model idle-ready:
  - block = 128'h000102030405060708090A0B0C0D0E0F.
  - next pulses exactly once, one cycle after the 16th strobe.
- Core model drops ready for 50 cycles, then raises it with core_result = 128'hDEADBEEF…:
  - result = that value; result_valid is a single-cycle pulse.
  - busy falls the same cycle as result_valid.
- core_ready = 0 when the 16th byte arrives: next stays low until ready rises, then pulses for exactly one cycle.
- Byte strobed during WAIT_DONE: overrun pulses once, byte_ctr is unchanged, the next block assembles correctly.
- TIMEOUT_CYCLES = 10:
  - 5 bytes, then 10 idle cycles → timeout pulses and byte_ctr = 0.
  - 16 fresh bytes then produce a correct block and next.
  - Byte strobed on the expiry cycle → accepted, no timeout.
- reset_n asserted during WAIT_DONE: all outputs return to reset values the next cycle; a following 16-byte block completes normally.
